// File: rtl/tower_sum_accumulator.sv
// tower_sum_accumulator
//
// Folds a stream of GF(2^8) tower-field products into one sum by XOR
// (field addition). A burst ends on a beat marked in_last, or is forced
// closed once MAX_TERMS terms have been folded. The closed sum is then
// presented on the output handshake. While the sum is held, a new burst
// may begin in the same cycle the sum is taken, so bursts run
// back-to-back without a bubble.
//
// Parameters
//   MAX_TERMS  maximum terms per sum before forced closure (1..2^CNT_W-1)
//   CNT_W      width of the term counter
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   product beat present
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_data    8-bit tower product
//   in_last    beat is the final term of the current sum
//   out_valid  sum available
//   out_ready  downstream takes the sum
//   out_data   XOR sum of the burst
//   out_ovf    burst was closed by MAX_TERMS rather than by in_last
//   out_cnt    number of terms in the sum (only with TERM_COUNT_EN)
//
// Configuration
//   TERM_COUNT_EN  when defined, exposes the term counter on out_cnt.
//                  The counter exists either way, since it enforces
//                  MAX_TERMS and drives out_ovf.

module tower_sum_accumulator #(
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
`ifdef TERM_COUNT_EN
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
`else
    output logic             out_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             start_new;
    logic [7:0]       next_acc;
    logic [CNT_W-1:0] next_cnt;
    logic             close_burst;

    // While a sum is held, the input may only move when the sum is being
    // taken this cycle; that is what lets a new burst start without a gap.
    always_comb begin
        in_ready = 1'b1;
        if (state == HOLD) begin
            in_ready = out_ready;
        end
    end

    // An accepted beat in IDLE or HOLD opens a fresh sum; in ACCUM it is
    // folded into the running sum. Closure happens either on in_last or
    // when the new count reaches MAX_TERMS.
    always_comb begin
        accept      = in_valid & in_ready;
        start_new   = (state != ACCUM);
        next_acc    = in_data;
        next_cnt    = CNT_W'(1);
        if (!start_new) begin
            next_acc = acc ^ in_data;
            next_cnt = cnt + CNT_W'(1);
        end
        close_burst = in_last | (next_cnt == MAX_CNT);
    end

    // Single state register plus the sum, count and overflow flag. The
    // overflow flag is only rewritten when a burst closes, so it stays
    // stable for the whole time the sum is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 8'h00;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= next_acc;
            cnt <= next_cnt;
            if (close_burst) begin
                state <= HOLD;
                ovf   <= ~in_last;
            end else begin
                state <= ACCUM;
            end
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

    // Outputs come straight from registers; out_data is only meaningful
    // while out_valid is high.
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_ovf   = ovf;
`ifdef TERM_COUNT_EN
    assign out_cnt   = cnt;
`endif

endmodule

// File: tb/tb_tower_sum_accumulator.sv
// Testbench for tower_sum_accumulator, built with MAX_TERMS = 4 so that
// forced closure is reached quickly. A transaction-level reference model
// keeps the terms of the open burst in a queue and the presented sum as a
// single pending record; every cycle the DUT handshake and outputs are
// compared against it. Directed scenarios additionally compare against
// hand-computed constants.

module tb_tower_sum_accumulator;

    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = 9;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_ovf;
`ifdef TERM_COUNT_EN
    logic [CNT_W-1:0] out_cnt;
`endif

    int test_count;
    int fail_count;

    // Reference model state
    logic [7:0] terms[$];
    bit         pending;
    logic [7:0] exp_sum;
    int         exp_cnt;
    bit         exp_ovf;

    tower_sum_accumulator #(
        .MAX_TERMS(MAX_TERMS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef TERM_COUNT_EN
        .out_ovf  (out_ovf),
        .out_cnt  (out_cnt)
`else
        .out_ovf  (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'd0);
        checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef TERM_COUNT_EN
        checkOutput("rst_out_cnt",   32'(out_cnt),   32'd0);
`endif
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        #1;
        checkReset();
        terms.delete();
        pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check the handshake against the model,
    // clock, advance the model, then check the registered outputs.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l,
                                 input bit r);
        bit exp_ready;
        bit accepted;
        logic [7:0] s;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_ready = !pending || r;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        accepted = v && exp_ready;
        @(posedge clk);
        #1;
        if (pending && r) pending = 1'b0;
        if (accepted) begin
            terms.push_back(d);
            if (l || terms.size() == MAX_TERMS) begin
                s = 8'h00;
                foreach (terms[i]) s = s ^ terms[i];
                exp_sum = s;
                exp_cnt = terms.size();
                exp_ovf = !l;
                pending = 1'b1;
                terms.delete();
            end
        end
        checkOutput("out_valid", 32'(out_valid), 32'(pending));
        if (pending) begin
            checkOutput("out_data", 32'(out_data), 32'(exp_sum));
            checkOutput("out_ovf",  32'(out_ovf),  32'(exp_ovf));
`ifdef TERM_COUNT_EN
            checkOutput("out_cnt",  32'(out_cnt),  32'(exp_cnt));
`endif
        end
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        pending    = 1'b0;
        exp_sum    = 8'h00;
        exp_cnt    = 0;
        exp_ovf    = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        #1;
        checkReset();
        #20;
        rst_n = 1'b1;

        // Three-term sum
        applyStimulus(1, 8'h12, 0, 1);
        applyStimulus(1, 8'h34, 0, 1);
        applyStimulus(1, 8'h56, 1, 1);
        checkOutput("three_data",  32'(out_data),  32'h70);
        checkOutput("three_ovf",   32'(out_ovf),   32'd0);
        checkOutput("three_valid", 32'(out_valid), 32'd1);
`ifdef TERM_COUNT_EN
        checkOutput("three_cnt",   32'(out_cnt),   32'd3);
`endif
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("three_one_cycle", 32'(out_valid), 32'd0);

        // Single beat held by backpressure; offered beats must be refused
        applyStimulus(1, 8'hA5, 1, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'($urandom), 1, 0);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("hold_data", 32'(out_data), 32'hA5);
`ifdef TERM_COUNT_EN
        checkOutput("hold_cnt",  32'(out_cnt),  32'd1);
`endif
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("hold_release", 32'(out_valid), 32'd0);

        // Forced closure at MAX_TERMS, then a fresh sum
        applyStimulus(1, 8'h01, 0, 1);
        applyStimulus(1, 8'h02, 0, 1);
        applyStimulus(1, 8'h04, 0, 1);
        applyStimulus(1, 8'h08, 0, 1);
        checkOutput("max_data", 32'(out_data), 32'h0F);
        checkOutput("max_ovf",  32'(out_ovf),  32'd1);
`ifdef TERM_COUNT_EN
        checkOutput("max_cnt",  32'(out_cnt),  32'd4);
`endif
        applyStimulus(1, 8'h10, 0, 1);
        checkOutput("max_next_open", 32'(out_valid), 32'd0);
        applyStimulus(1, 8'h20, 1, 1);
        checkOutput("max_next_data", 32'(out_data), 32'h30);
        checkOutput("max_next_ovf",  32'(out_ovf),  32'd0);

        // in_last on exactly the MAX_TERMS-th beat is not an overflow
        applyStimulus(1, 8'h11, 0, 1);
        applyStimulus(1, 8'h22, 0, 1);
        applyStimulus(1, 8'h44, 0, 1);
        applyStimulus(1, 8'h88, 1, 1);
        checkOutput("edge_data", 32'(out_data), 32'hFF);
        checkOutput("edge_ovf",  32'(out_ovf),  32'd0);

        // Back-to-back bursts with no bubble
        applyStimulus(1, 8'hFF, 0, 1);
        applyStimulus(1, 8'h0F, 1, 1);
        checkOutput("b2b_first", 32'(out_data), 32'hF0);
        applyStimulus(1, 8'h33, 1, 1);
        checkOutput("b2b_second",       32'(out_data),  32'h33);
        checkOutput("b2b_second_valid", 32'(out_valid), 32'd1);
        applyStimulus(0, 8'h00, 0, 1);

        // Reset mid-burst discards the partial sum
        applyStimulus(1, 8'h11, 0, 1);
        applyStimulus(1, 8'h22, 0, 1);
        applyReset();
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        applyStimulus(1, 8'h44, 1, 1);
        checkOutput("midrst_data", 32'(out_data), 32'h44);
`ifdef TERM_COUNT_EN
        checkOutput("midrst_cnt",  32'(out_cnt),  32'd1);
`endif

        // Randomised traffic against the model, with one reset in the middle
        for (int n = 0; n < 600; n++) begin
            if (n == 300) applyReset();
            applyStimulus(($urandom % 4) != 0, 8'($urandom),
                          ($urandom % 5) == 0, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/tower_sum_accumulator.md
TOWER_SUM_ACCUMULATOR -- requirements
Module: tower_sum_accumulator

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 256: maximum product terms folded into one sum before forced closure; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 9: width of the term counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  product beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port in_data  input  8  GF(2^8) tower product, bit i = product bit i (from the upstream 8-bit tower multiplier y0..y7).
REQ-008 SHALL have port in_last  input  1  beat is the final term of the current sum.
REQ-009 SHALL have port out_valid  output  1  sum available.
REQ-010 SHALL have port out_ready  input  1  downstream takes the sum.
REQ-011 SHALL have port out_data  output  8  XOR sum of all accepted terms of the burst.
REQ-012 SHALL have port out_ovf  output  1  burst closed by MAX_TERMS rather than by in_last.
REQ-013 SHALL have port out_cnt  output  CNT_W  number of terms in the sum (present only under TERM_COUNT_EN).

Function
REQ-014 SHALL implement states IDLE (no term held), ACCUM (>=1 term, burst open) and HOLD (sum presented).
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM; in_ready = out_ready in HOLD.
REQ-016 SHALL accept a beat when in_valid & in_ready; in_data and in_last are ignored otherwise.
REQ-017 In IDLE, an accepted beat SHALL set acc = in_data and cnt = 1.
REQ-018 In ACCUM, an accepted beat SHALL set acc = acc XOR in_data (field addition, no carries) and cnt = cnt + 1.
REQ-019 After an accepted beat, the block SHALL go to HOLD if in_last = 1 or the new cnt = MAX_TERMS; otherwise to (or stay in) ACCUM.
REQ-020 On entry to HOLD, out_ovf SHALL be set to 1 iff the closing beat had in_last = 0; otherwise it SHALL be 0.
REQ-021 In HOLD, out_valid SHALL be 1, and out_data, out_cnt and out_ovf SHALL remain stable until out_ready = 1.
REQ-022 In HOLD with out_ready = 1 and no accepted beat, the block SHALL go to IDLE.
REQ-023 In HOLD with out_ready = 1 and an accepted beat, the block SHALL treat that beat as an IDLE accept (REQ-017, REQ-019), giving bubble-free back-to-back bursts.
REQ-024 Latency: out_valid SHALL rise the cycle after the closing beat is accepted; sustained throughput SHALL be one term per cycle.
REQ-025 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-026 With MAX_TERMS = 1, every accepted beat SHALL close a burst; out_ovf SHALL be 1 exactly when that beat has in_last = 0.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_cnt = 0, in_ready = 1 (after release).
REQ-028 Reset asserted mid-burst or in HOLD SHALL discard the partial or pending sum, with no output produced for it.

Configuration
REQ-029 With macro TERM_COUNT_EN defined, the out_cnt port SHALL exist and carry cnt, held stable in HOLD.
REQ-030 Without TERM_COUNT_EN, out_cnt SHALL be absent; the internal counter SHALL still exist to enforce MAX_TERMS and out_ovf, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Three beats 0x12, 0x34, 0x56 (last on 0x56), out_ready = 1 -> one cycle later out_data = 0x70, out_cnt = 3, out_ovf = 0, out_valid for one cycle.
REQ-032 Single beat 0xA5 with last -> out_data = 0xA5, out_cnt = 1; with out_ready held 0 for 5 cycles -> outputs stable, in_ready = 0, no beat accepted.
REQ-033 MAX_TERMS = 4; beats 0x01, 0x02, 0x04, 0x08, none with last -> out_data = 0x0F, out_ovf = 1, out_cnt = 4; fifth beat 0x10 starts a new sum.
REQ-034 Back-to-back bursts {0xFF, 0x0F last} then {0x33 last} with out_ready = 1 and in_valid held -> out_data 0xF0 then 0x33 on consecutive out_valid beats, in_ready never 0.
REQ-035 rst_n pulsed low after beats 0x11, 0x22 (no last) -> no out_valid; then 0x44 last -> out_data = 0x44, out_cnt = 1.
